// File: rtl/serial_word_collector_if.sv
// ----------------------------------------------------------------------------
// serial_word_collector_if
// Bundles the serial input side and the word handshake side of
// serial_word_collector.
//   master : upstream/consumer view. Drives Direccion, start, bit_valid,
//            ser_msb, ser_lsb and word_ready. Observes word_out, word_valid,
//            busy, overrun and parity_err.
//   slave  : collector view, with the opposite directions.
// Parameter WIDTH must match the collector's WIDTH.
// ----------------------------------------------------------------------------
interface serial_word_collector_if #(
    parameter int WIDTH = 8
);
    logic             Direccion;
    logic             start;
    logic             bit_valid;
    logic             ser_msb;
    logic             ser_lsb;
    logic             word_ready;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             busy;
    logic             overrun;
    logic             parity_err;

    modport master (
        output Direccion, start, bit_valid, ser_msb, ser_lsb, word_ready,
        input  word_out, word_valid, busy, overrun, parity_err
    );

    modport slave (
        input  Direccion, start, bit_valid, ser_msb, ser_lsb, word_ready,
        output word_out, word_valid, busy, overrun, parity_err
    );
endinterface

// File: rtl/serial_word_collector.sv
// ----------------------------------------------------------------------------
// serial_word_collector
// Collects WIDTH serial bits from one end of the upstream bidirectional shift
// register into a parallel word. The word is offered on a valid/ready
// handshake. While a word is held, incoming bits are dropped and recorded in a
// sticky overrun flag.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : serial_word_collector_if.slave
//         Direccion  - 1: sample ser_msb, first bit lands in the MSB
//                      0: sample ser_lsb, first bit lands in the LSB
//         start      - begin or restart a frame, latches Direccion
//         bit_valid  - the selected serial line carries a bit
//         word_out   - assembled word (registered)
//         word_valid / word_ready - output handshake
//         busy       - frame collection in progress
//         overrun    - sticky, a bit arrived while a word was held
//         parity_err - even-parity mismatch of the held word
//
// Optional feature macro: SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
//   When defined, one extra parity bit follows the data bits and parity_err
//   reports (^word) ^ parity_bit. When undefined, parity_err is tied to 0.
// ----------------------------------------------------------------------------
module serial_word_collector #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    serial_word_collector_if.slave  bus
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_PARITY, S_HOLD} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;
`endif

    state_t           r_state;
    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_dir;
    logic [WIDTH-1:0] r_word_out;
    logic             r_word_valid;
    logic             r_busy;
    logic             r_overrun;
    logic [WIDTH-1:0] w_sh_next;

`ifdef SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
    logic             r_parity_err;
    logic             w_bit;

    // Parity bit comes from the same end as the data bits.
    assign w_bit = r_dir ? bus.ser_msb : bus.ser_lsb;
`endif

    // MSB-first shifts left so the first bit ends at the top;
    // LSB-first shifts right so the first bit ends at bit 0.
    always_comb begin
        w_sh_next = r_sh;
        if (r_dir) begin
            w_sh_next = {r_sh[WIDTH-2:0], bus.ser_msb};
        end else begin
            w_sh_next = {bus.ser_lsb, r_sh[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_sh         <= '0;
            r_cnt        <= '0;
            r_dir        <= 1'b0;
            r_word_out   <= '0;
            r_word_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state   <= S_COLLECT;
                        r_sh      <= '0;
                        r_cnt     <= '0;
                        r_dir     <= bus.Direccion;
                        r_overrun <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end

                S_COLLECT: begin
                    // start has priority over a simultaneous bit.
                    if (bus.start) begin
                        r_sh  <= '0;
                        r_cnt <= '0;
                        r_dir <= bus.Direccion;
                    end else if (bus.bit_valid) begin
                        r_sh <= w_sh_next;
                        if (r_cnt == LAST) begin
                            r_cnt <= '0;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
                            r_state <= S_PARITY;
`else
                            r_state      <= S_HOLD;
                            r_word_out   <= w_sh_next;
                            r_word_valid <= 1'b1;
                            r_busy       <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end

`ifdef SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
                S_PARITY: begin
                    if (bus.start) begin
                        r_state <= S_COLLECT;
                        r_sh    <= '0;
                        r_cnt   <= '0;
                        r_dir   <= bus.Direccion;
                    end else if (bus.bit_valid) begin
                        r_state      <= S_HOLD;
                        r_word_out   <= r_sh;
                        r_parity_err <= (^r_sh) ^ w_bit;
                        r_word_valid <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
`endif

                S_HOLD: begin
                    if (bus.word_ready) begin
                        r_word_valid <= 1'b0;
                        // start in the transfer cycle chains straight into
                        // the next frame.
                        if (bus.start) begin
                            r_state   <= S_COLLECT;
                            r_sh      <= '0;
                            r_cnt     <= '0;
                            r_dir     <= bus.Direccion;
                            r_overrun <= 1'b0;
                            r_busy    <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (bus.bit_valid) begin
                        r_overrun <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.word_out   = r_word_out;
    assign bus.word_valid = r_word_valid;
    assign bus.busy       = r_busy;
    assign bus.overrun    = r_overrun;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
    assign bus.parity_err = r_parity_err;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_collector.sv
// ----------------------------------------------------------------------------
// tb_serial_word_collector
// Directed scenarios plus a randomized run against a bit-queue reference
// model of the collector. Build with SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
// defined to exercise the parity variant.
// ----------------------------------------------------------------------------
module tb_serial_word_collector;

    localparam int W = 8;
`ifdef SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic cur_dir = 1'b0;

    serial_word_collector_if #(.WIDTH(W)) bus ();

    serial_word_collector #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic         m_busy, m_valid, m_over, m_perr, m_dir;
    logic [W-1:0] m_word;
    logic         m_q[$];

    function automatic void model_reset();
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_over  = 1'b0;
        m_perr  = 1'b0;
        m_dir   = 1'b0;
        m_word  = '0;
        m_q.delete();
    endfunction

    function automatic void model_begin();
        m_busy = 1'b1;
        m_dir  = bus.Direccion;
        m_over = 1'b0;
        m_q.delete();
    endfunction

    function automatic void model_edge();
        logic [W-1:0] w;
        logic         p;
        if (m_valid) begin
            if (bus.word_ready) begin
                m_valid = 1'b0;
                if (bus.start) model_begin();
            end else if (bus.bit_valid) begin
                m_over = 1'b1;
            end
        end else if (m_busy) begin
            if (bus.start) begin
                model_begin();
            end else if (bus.bit_valid) begin
                m_q.push_back(m_dir ? bus.ser_msb : bus.ser_lsb);
                if (m_q.size() == W + PAR) begin
                    w = '0;
                    p = 1'b0;
                    for (int i = 0; i < W; i++) begin
                        if (m_dir) w[W-1-i] = m_q[i];
                        else       w[i]     = m_q[i];
                    end
                    foreach (m_q[i]) p = p ^ m_q[i];
                    m_word  = w;
                    m_perr  = (PAR != 0) ? p : 1'b0;
                    m_valid = 1'b1;
                    m_busy  = 1'b0;
                    m_q.delete();
                end
            end
        end else if (bus.start) begin
            model_begin();
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        if (rst) model_reset();
        else     model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_bit(input logic b);
        bus.bit_valid = 1'b1;
        if (cur_dir) begin
            bus.ser_msb = b;
            bus.ser_lsb = 1'($urandom);
        end else begin
            bus.ser_lsb = b;
            bus.ser_msb = 1'($urandom);
        end
        tick();
        bus.bit_valid = 1'b0;
    endtask

    // Bits are taken from pat starting at pat[W-1-first].
    task automatic feed(input logic [W-1:0] pat, input int first, input int n,
                        input logic flip);
        for (int i = first; i < first + n; i++) begin
            if (flip) bus.Direccion = ~bus.Direccion;
            feed_bit(pat[W-1-i]);
        end
    endtask

    task automatic do_start(input logic dir);
        bus.Direccion = dir;
        cur_dir       = dir;
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic frame_bits(input logic [W-1:0] pat, input logic flip);
        feed(pat, 0, W, flip);
        if (PAR != 0) feed_bit(^pat);
    endtask

    task automatic consume();
        bus.word_ready = 1'b1;
        tick();
        bus.word_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            bus.start     = 1'($urandom);
            bus.bit_valid = 1'($urandom);
            bus.ser_msb   = 1'($urandom);
            bus.ser_lsb   = 1'($urandom);
            tick();
            checks++;
            if ({bus.word_out, bus.word_valid, bus.busy, bus.overrun, bus.parity_err} !== '0) begin
                errors++;
                $display("FAIL reset_outputs got word=%h v=%b b=%b o=%b p=%b expected all 0",
                         bus.word_out, bus.word_valid, bus.busy, bus.overrun, bus.parity_err);
            end
        end
        bus.start     = 1'b0;
        bus.bit_valid = 1'b0;
        rst           = 1'b0;
        tick();
    endtask

    task automatic test_msb_first();
        do_start(1'b1);
        checks++;
        if (bus.busy !== 1'b1 || bus.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_busy_after_start got busy=%b valid=%b expected 1 0",
                     bus.busy, bus.word_valid);
        end
        feed(8'hB2, 0, W - 1, 1'b0);
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL msb_early_valid got %b expected 0", bus.word_valid);
        end
        feed(8'hB2, W - 1, 1, 1'b0);
`ifdef SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
        checks++;
        if (bus.word_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL msb_valid_before_parity got valid=%b busy=%b expected 0 1",
                     bus.word_valid, bus.busy);
        end
        feed_bit(1'b0);
`endif
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hB2 || bus.busy !== 1'b0
            || bus.parity_err !== 1'b0) begin
            errors++;
            $display("FAIL msb_word got v=%b word=%h busy=%b perr=%b expected 1 b2 0 0",
                     bus.word_valid, bus.word_out, bus.busy, bus.parity_err);
        end
        consume();
        checks++;
        if (bus.word_valid !== 1'b0 || bus.busy !== 1'b0 || bus.word_out !== 8'hB2) begin
            errors++;
            $display("FAIL msb_after_transfer got v=%b busy=%b word=%h expected 0 0 b2",
                     bus.word_valid, bus.busy, bus.word_out);
        end
    endtask

    task automatic test_lsb_first();
        do_start(1'b0);
        frame_bits(8'hB2, 1'b1);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 8'h4D) begin
            errors++;
            $display("FAIL lsb_word got v=%b word=%h expected 1 4d",
                     bus.word_valid, bus.word_out);
        end
    endtask

    task automatic test_backpressure();
        bus.word_ready = 1'b0;
        tick();
        feed_bit(1'b1);
        tick();
        checks++;
        if (bus.overrun !== 1'b1 || bus.word_out !== 8'h4D || bus.word_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_overrun got ovr=%b word=%h v=%b expected 1 4d 1",
                     bus.overrun, bus.word_out, bus.word_valid);
        end
        consume();
        checks++;
        if (bus.word_valid !== 1'b0 || bus.overrun !== 1'b1) begin
            errors++;
            $display("FAIL bp_transfer got v=%b ovr=%b expected 0 1",
                     bus.word_valid, bus.overrun);
        end
        do_start(1'b1);
        checks++;
        if (bus.overrun !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_start_clears got ovr=%b busy=%b expected 0 1",
                     bus.overrun, bus.busy);
        end
    endtask

    task automatic test_restart();
        feed(W'($urandom), 0, 3, 1'b0);
        do_start(1'b1);
        checks++;
        if (bus.word_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_state got v=%b busy=%b expected 0 1",
                     bus.word_valid, bus.busy);
        end
        feed(8'hB2, 0, W - 1, 1'b0);
        checks++;
        if (bus.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_early_valid got %b expected 0", bus.word_valid);
        end
        feed(8'hB2, W - 1, 1, 1'b0);
        if (PAR != 0) feed_bit(1'b0);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hB2) begin
            errors++;
            $display("FAIL restart_word got v=%b word=%h expected 1 b2",
                     bus.word_valid, bus.word_out);
        end
        consume();
    endtask

    task automatic test_reset_midframe();
        do_start(1'b0);
        feed(W'($urandom), 0, 4, 1'b0);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({bus.word_out, bus.word_valid, bus.busy, bus.overrun, bus.parity_err} !== '0) begin
            errors++;
            $display("FAIL async_reset got word=%h v=%b b=%b o=%b p=%b expected all 0",
                     bus.word_out, bus.word_valid, bus.busy, bus.overrun, bus.parity_err);
        end
        tick();
        rst = 1'b0;
        bus.bit_valid = 1'b1;
        tick();
        bus.bit_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b0 || bus.word_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b v=%b expected 0 0",
                     bus.busy, bus.word_valid);
        end
    endtask

`ifdef SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
    task automatic test_parity();
        for (int k = 0; k < 2; k++) begin
            logic pb;
            pb = (k == 0) ? 1'b1 : 1'b0;
            do_start(1'b1);
            feed(8'hB2, 0, W, 1'b0);
            checks++;
            if (bus.word_valid !== 1'b0) begin
                errors++;
                $display("FAIL parity_early_valid got %b expected 0", bus.word_valid);
            end
            feed_bit(pb);
            checks++;
            if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hB2 || bus.parity_err !== pb) begin
                errors++;
                $display("FAIL parity_err got v=%b word=%h perr=%b expected 1 b2 %b",
                         bus.word_valid, bus.word_out, bus.parity_err, pb);
            end
            consume();
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [W-1:0] p1, p2, exp2;
        p1 = W'($urandom);
        p2 = W'($urandom);
        do_start(1'b1);
        frame_bits(p1, 1'b0);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== p1) begin
            errors++;
            $display("FAIL b2b_first got v=%b word=%h expected 1 %h",
                     bus.word_valid, bus.word_out, p1);
        end
        bus.Direccion  = 1'b0;
        cur_dir        = 1'b0;
        bus.word_ready = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.word_ready = 1'b0;
        bus.start      = 1'b0;
        checks++;
        if (bus.word_valid !== 1'b0 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_chain got v=%b busy=%b expected 0 1",
                     bus.word_valid, bus.busy);
        end
        frame_bits(p2, 1'b0);
        for (int i = 0; i < W; i++) exp2[i] = p2[W-1-i];
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word_out !== exp2) begin
            errors++;
            $display("FAIL b2b_second got v=%b word=%h expected 1 %h",
                     bus.word_valid, bus.word_out, exp2);
        end
        consume();
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            bus.start      = ($urandom_range(0, 99) < 4);
            bus.bit_valid  = ($urandom_range(0, 99) < 70);
            bus.word_ready = ($urandom_range(0, 99) < 30);
            bus.Direccion  = 1'($urandom);
            bus.ser_msb    = 1'($urandom);
            bus.ser_lsb    = 1'($urandom);
            tick();
            checks++;
            if (bus.word_valid !== m_valid || bus.busy !== m_busy) begin
                errors++;
                $display("FAIL rnd_ctrl cyc %0d got v=%b busy=%b expected %b %b",
                         i, bus.word_valid, bus.busy, m_valid, m_busy);
            end
            checks++;
            if (bus.word_out !== m_word) begin
                errors++;
                $display("FAIL rnd_word cyc %0d got %h expected %h", i, bus.word_out, m_word);
            end
            checks++;
            if (bus.overrun !== m_over || bus.parity_err !== m_perr) begin
                errors++;
                $display("FAIL rnd_flags cyc %0d got ovr=%b perr=%b expected %b %b",
                         i, bus.overrun, bus.parity_err, m_over, m_perr);
            end
        end
        bus.start      = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.word_ready = 1'b0;
    endtask

    initial begin
        bus.Direccion  = 1'b0;
        bus.start      = 1'b0;
        bus.bit_valid  = 1'b0;
        bus.ser_msb    = 1'b0;
        bus.ser_lsb    = 1'b0;
        bus.word_ready = 1'b0;
        model_reset();
        #1;
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_restart();
        test_reset_midframe();
`ifdef SERIAL_WORD_COLLECTOR_PARITY_CHECK_EN
        test_parity();
`endif
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
